led_fader: RTL

LED_FADER -- requirements
Module: led_fader

---
 rtl/led_fader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/led_fader.sv
// LED fader: q_in fades led_r up/down through a PWM, led_g marks a fade, led_b is a heartbeat.
// Optional macro LED_FADER_GAMMA_EN squares the brightness before it is used as PWM duty.
module led_fader #(
    parameter int PRESCALE = 64,
    parameter int STEP     = 8
) (
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic q_in,
    output logic led_r,
    output logic led_g,
    output logic led_b
);

    // state | meaning
    // OFF   | dark, level held at 0, waiting for q_s=1
    // UP    | level rises by STEP each frame tick
    // ON    | fully lit, level held at 255, waiting for q_s=0
    // DOWN  | level falls by STEP each frame tick
    typedef enum logic [1:0] {OFF, UP, ON, DOWN} state_t;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [8:0] STEP9 = 9'(STEP);

    state_t        state;
    logic          q_m;
    logic          q_s;
    logic [PW-1:0] pre_cnt;
    logic [7:0]    pwm_cnt;
    logic [7:0]    frame_cnt;
    logic [7:0]    level;
    logic [7:0]    duty;
    logic          pwm_tick;
    logic          frame_tick;
    logic [8:0]    level_up;
    logic [8:0]    level_dn;
    logic [7:0]    up_sat;
    logic [7:0]    dn_sat;

    assign pwm_tick   = (pre_cnt == PRE_MAX);
    assign frame_tick = pwm_tick && (pwm_cnt == 8'hFF);

    // 9-bit arithmetic: bit 8 flags overflow on the way up and borrow on the way down
    assign level_up = {1'b0, level} + STEP9;
    assign level_dn = {1'b0, level} - STEP9;
    assign up_sat   = level_up[8] ? 8'hFF : level_up[7:0];
    assign dn_sat   = level_dn[8] ? 8'h00 : level_dn[7:0];

`ifdef LED_FADER_GAMMA_EN
    logic [15:0] level_sq;
    assign level_sq = {8'd0, level} * {8'd0, level};
    assign duty     = level_sq[15:8];
`else
    assign duty = level;
`endif

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            q_m       <= 1'b0;
            q_s       <= 1'b0;
            pre_cnt   <= '0;
            pwm_cnt   <= 8'd0;
            frame_cnt <= 8'd0;
            level     <= 8'd0;
            state     <= OFF;
            led_r     <= 1'b1;
            led_g     <= 1'b1;
            led_b     <= 1'b1;
        end else begin
            q_m <= q_in;
            q_s <= q_m;

            pre_cnt <= pwm_tick ? '0 : pre_cnt + PW'(1);
            if (pwm_tick)
                pwm_cnt <= pwm_cnt + 8'd1;
            if (frame_tick) begin
                frame_cnt <= frame_cnt + 8'd1;
                if (frame_cnt == 8'hFF)
                    led_b <= ~led_b;
            end

            // a q_s change takes priority over a frame tick; level is held that cycle
            case (state)
                OFF: begin
                    level <= 8'd0;
                    if (q_s)
                        state <= UP;
                end
                UP: begin
                    if (!q_s)
                        state <= DOWN;
                    else if (frame_tick) begin
                        level <= up_sat;
                        if (up_sat == 8'hFF)
                            state <= ON;
                    end
                end
                ON: begin
                    level <= 8'hFF;
                    if (!q_s)
                        state <= DOWN;
                end
                DOWN: begin
                    if (q_s)
                        state <= UP;
                    else if (frame_tick) begin
                        level <= dn_sat;
                        if (dn_sat == 8'h00)
                            state <= OFF;
                    end
                end
                default: state <= OFF;
            endcase

            led_r <= !((state == ON) || (pwm_cnt < duty));
            led_g <= !((state == UP) || (state == DOWN));
        end
    end

endmodule
